// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, forwarding select
// codes and the immediate-extension helper used at capture time.
package id_ex_stage_pkg;

  localparam int ALU_CONTROL_LENGTH = 3;

  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_AND = 3'b000;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_OR  = 3'b001;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_ADD = 3'b010;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_SUB = 3'b110;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_SLT = 3'b111;

  // Operand source chosen by a forwarding mux
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  // 16-bit immediate to 32 bits: zero-extend for logical ops (ORI), else sign-extend
  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
    return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID-side inputs, the M/W forwarding sources and the EX-side
// outputs of the ID/EX stage. The stage itself uses the slave modport.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) ();

  logic                          stall;
  logic                          flush;
  logic [DATA_W-1:0]             rd1_d;
  logic [DATA_W-1:0]             rd2_d;
  logic [15:0]                   imm_d;
  logic [REG_ADDR_W-1:0]         rs_d;
  logic [REG_ADDR_W-1:0]         rt_d;
  logic [REG_ADDR_W-1:0]         rd_d;
  logic [ALU_CONTROL_LENGTH-1:0] alu_cont_d;
  logic                          alusrc_d;
  logic                          regdst_d;
  logic                          ext_zero_d;
  logic                          regwrite_d;
  logic                          memwrite_d;
  logic                          memtoreg_d;
  logic                          regwrite_m;
  logic [REG_ADDR_W-1:0]         writereg_m;
  logic [DATA_W-1:0]             aluout_m;
  logic                          regwrite_w;
  logic [REG_ADDR_W-1:0]         writereg_w;
  logic [DATA_W-1:0]             result_w;
  logic [DATA_W-1:0]             SrcA;
  logic [DATA_W-1:0]             SrcB;
  logic [ALU_CONTROL_LENGTH-1:0] alu_cont_e;
  logic [DATA_W-1:0]             writedata_e;
  logic [REG_ADDR_W-1:0]         writereg_e;
  logic                          regwrite_e;
  logic                          memwrite_e;
  logic                          memtoreg_e;

  modport master (
    output stall, flush, rd1_d, rd2_d, imm_d, rs_d, rt_d, rd_d, alu_cont_d,
           alusrc_d, regdst_d, ext_zero_d, regwrite_d, memwrite_d, memtoreg_d,
           regwrite_m, writereg_m, aluout_m, regwrite_w, writereg_w, result_w,
    input  SrcA, SrcB, alu_cont_e, writedata_e, writereg_e,
           regwrite_e, memwrite_e, memtoreg_e
  );

  modport slave (
    input  stall, flush, rd1_d, rd2_d, imm_d, rs_d, rt_d, rd_d, alu_cont_d,
           alusrc_d, regdst_d, ext_zero_d, regwrite_d, memwrite_d, memtoreg_d,
           regwrite_m, writereg_m, aluout_m, regwrite_w, writereg_w, result_w,
    output SrcA, SrcB, alu_cont_e, writedata_e, writereg_e,
           regwrite_e, memwrite_e, memtoreg_e
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One forwarding path: compares a source register address against the
// EX/MEM and MEM/WB destinations and picks the freshest value.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     reg_val,
  input  logic                  regwrite_m,
  input  logic [REG_ADDR_W-1:0] writereg_m,
  input  logic [DATA_W-1:0]     aluout_m,
  input  logic                  regwrite_w,
  input  logic [REG_ADDR_W-1:0] writereg_w,
  input  logic [DATA_W-1:0]     result_w,
  output logic [DATA_W-1:0]     operand
);

  logic [1:0] fwd_sel;

  // Select source; M is tested last so it overrides W. Register 0 never forwards.
  always_comb begin
    fwd_sel = FWD_NONE;
    if (regwrite_w && (writereg_w != '0) && (writereg_w == src_addr))
      fwd_sel = FWD_W;
    if (regwrite_m && (writereg_m != '0) && (writereg_m == src_addr))
      fwd_sel = FWD_M;
  end

  // 3:1 data select
  always_comb begin
    case (fwd_sel)
      FWD_M:   operand = aluout_m;
      FWD_W:   operand = result_w;
      default: operand = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, immediate extension at capture,
// and M/W result forwarding feeding the ALU operands and store data.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic [DATA_W-1:0]             rd1_reg;
  logic [DATA_W-1:0]             rd2_reg;
  logic [DATA_W-1:0]             immext_reg;
  logic [REG_ADDR_W-1:0]         rs_reg;
  logic [REG_ADDR_W-1:0]         rt_reg;
  logic [REG_ADDR_W-1:0]         writereg_reg;
  logic [ALU_CONTROL_LENGTH-1:0] alu_cont_reg;
  logic                          alusrc_reg;
  logic                          regwrite_reg;
  logic                          memwrite_reg;
  logic                          memtoreg_reg;

  logic [DATA_W-1:0]             fwd_a;
  logic [DATA_W-1:0]             fwd_b;

  // Stage register: reset and flush both load an all-zero bubble; stall holds
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      immext_reg   <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      writereg_reg <= '0;
      alu_cont_reg <= '0;
      alusrc_reg   <= 1'b0;
      regwrite_reg <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
    end else if (!bus.stall) begin
      rd1_reg      <= bus.rd1_d;
      rd2_reg      <= bus.rd2_d;
      immext_reg   <= DATA_W'(extend_imm(bus.imm_d, bus.ext_zero_d));
      rs_reg       <= bus.rs_d;
      rt_reg       <= bus.rt_d;
      writereg_reg <= bus.regdst_d ? bus.rd_d : bus.rt_d;
      alu_cont_reg <= bus.alu_cont_d;
      alusrc_reg   <= bus.alusrc_d;
      regwrite_reg <= bus.regwrite_d;
      memwrite_reg <= bus.memwrite_d;
      memtoreg_reg <= bus.memtoreg_d;
    end
  end

  id_ex_stage_fwd_mux #(.REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) u_fwd_a (
    .src_addr   (rs_reg),
    .reg_val    (rd1_reg),
    .regwrite_m (bus.regwrite_m),
    .writereg_m (bus.writereg_m),
    .aluout_m   (bus.aluout_m),
    .regwrite_w (bus.regwrite_w),
    .writereg_w (bus.writereg_w),
    .result_w   (bus.result_w),
    .operand    (fwd_a)
  );

  id_ex_stage_fwd_mux #(.REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) u_fwd_b (
    .src_addr   (rt_reg),
    .reg_val    (rd2_reg),
    .regwrite_m (bus.regwrite_m),
    .writereg_m (bus.writereg_m),
    .aluout_m   (bus.aluout_m),
    .regwrite_w (bus.regwrite_w),
    .writereg_w (bus.writereg_w),
    .result_w   (bus.result_w),
    .operand    (fwd_b)
  );

  // ALU operands; store data always takes the forwarded rt value
  always_comb begin
    bus.SrcA        = fwd_a;
    bus.SrcB        = alusrc_reg ? immext_reg : fwd_b;
    bus.writedata_e = fwd_b;
  end

  // Registered controls straight to EX/MEM
  always_comb begin
    bus.alu_cont_e = alu_cont_reg;
    bus.writereg_e = writereg_reg;
    bus.regwrite_e = regwrite_reg;
    bus.memwrite_e = memwrite_reg;
    bus.memtoreg_e = memtoreg_reg;
  end

endmodule
